// File: rtl/max_spi_arbiter.sv
// Two-requester round-robin arbiter in front of a MAX3421E SPI master.
// Each grant runs one 16-bit mode-0 frame: a command byte, then a data byte.
module max_spi_arbiter #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       wr0,
  input  logic [4:0] addr0,
  input  logic [7:0] wdata0,
  input  logic       req1,
  input  logic       wr1,
  input  logic [4:0] addr1,
  input  logic [7:0] wdata1,
  output logic [1:0] done,
  output logic [7:0] rdata,
  output logic [7:0] status,
  output logic       busy,
  output logic       max_ss_n,
  output logic       max_sclk,
  output logic       max_mosi,
  input  logic       max_miso
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_e;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_e      state;
  state_e      state_d;
  logic [7:0]  div_cnt;
  logic        div_last;
  logic [3:0]  bit_cnt;
  logic        phase;      // 0 = SCLK low half of the bit, 1 = high half
  logic [14:0] tx_sr;      // bits still to be driven after the current one
  logic [15:0] rx_sr;
  logic        grant;
  logic        last_grant;
  logic        grant_sel;
  logic        req_any;
  logic [7:0]  cmd_sel;
  logic [7:0]  data_sel;

  assign req_any  = req0 | req1;
  assign div_last = (div_cnt == DIV_LAST);

  // Round-robin: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    grant_sel = req1;
    if (req0 && req1) begin
      grant_sel = ~last_grant;
    end
  end

  always_comb begin
    cmd_sel  = {addr0, 1'b0, wr0, 1'b0};
    data_sel = wr0 ? wdata0 : 8'h00;
    if (grant_sel) begin
      cmd_sel  = {addr1, 1'b0, wr1, 1'b0};
      data_sel = wr1 ? wdata1 : 8'h00;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (req_any) state_d = SETUP;
      SETUP:   if (div_last) state_d = SHIFT;
      SHIFT:   if (div_last && phase && (bit_cnt == 4'd15)) state_d = HOLD;
      HOLD:    if (div_last) state_d = GAP;
      GAP:     if (div_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      bit_cnt    <= '0;
      phase      <= 1'b0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      done       <= '0;
      rdata      <= '0;
      status     <= '0;
      busy       <= 1'b0;
      max_ss_n   <= 1'b1;
      max_sclk   <= 1'b0;
      max_mosi   <= 1'b0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          div_cnt <= '0;
          if (req_any) begin
            grant      <= grant_sel;
            last_grant <= grant_sel;
            tx_sr      <= {cmd_sel[6:0], data_sel};
            max_mosi   <= cmd_sel[7];
            max_ss_n   <= 1'b0;
            bit_cnt    <= '0;
            phase      <= 1'b0;
            busy       <= 1'b1;
          end
        end

        SETUP: begin
          div_cnt <= div_last ? 8'd0 : div_cnt + 8'd1;
        end

        SHIFT: begin
          if (!div_last) begin
            div_cnt <= div_cnt + 8'd1;
          end else begin
            div_cnt <= '0;
            if (!phase) begin
              // Rising SCLK edge: the slave's bit has been stable for a full low half.
              max_sclk <= 1'b1;
              phase    <= 1'b1;
              rx_sr    <= {rx_sr[14:0], max_miso};
            end else begin
              max_sclk <= 1'b0;
              phase    <= 1'b0;
              if (bit_cnt != 4'd15) begin
                bit_cnt  <= bit_cnt + 4'd1;
                max_mosi <= tx_sr[14];
                tx_sr    <= {tx_sr[13:0], 1'b0};
              end
            end
          end
        end

        HOLD: begin
          if (!div_last) begin
            div_cnt <= div_cnt + 8'd1;
          end else begin
            div_cnt  <= '0;
            max_ss_n <= 1'b1;
            done     <= grant ? 2'b10 : 2'b01;
            status   <= rx_sr[15:8];
            rdata    <= rx_sr[7:0];
          end
        end

        GAP: begin
          if (!div_last) begin
            div_cnt <= div_cnt + 8'd1;
          end else begin
            div_cnt <= '0;
            busy    <= 1'b0;
          end
        end

        default: begin
          div_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_max_spi_arbiter.sv
// Directed bench for max_spi_arbiter: one instance at CLK_DIV=4, one at CLK_DIV=1,
// each with a mode-0 SPI slave model on the pins.
module tb_max_spi_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // CLK_DIV=4 instance
  logic       req0, wr0, req1, wr1;
  logic [4:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic [1:0] done;
  logic [7:0] rdata, status;
  logic       busy, ss_n, sclk, mosi, miso;

  // CLK_DIV=1 instance
  logic       f_req0, f_wr0, f_req1, f_wr1;
  logic [4:0] f_addr0, f_addr1;
  logic [7:0] f_wdata0, f_wdata1;
  logic [1:0] f_done;
  logic [7:0] f_rdata, f_status;
  logic       f_busy, f_ss_n, f_sclk, f_mosi;
  logic       f_miso = 1'b1;

  max_spi_arbiter #(.CLK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
    .done(done), .rdata(rdata), .status(status), .busy(busy),
    .max_ss_n(ss_n), .max_sclk(sclk), .max_mosi(mosi), .max_miso(miso)
  );

  max_spi_arbiter #(.CLK_DIV(1)) dut_fast (
    .clk(clk), .rst_n(rst_n),
    .req0(f_req0), .wr0(f_wr0), .addr0(f_addr0), .wdata0(f_wdata0),
    .req1(f_req1), .wr1(f_wr1), .addr1(f_addr1), .wdata1(f_wdata1),
    .done(f_done), .rdata(f_rdata), .status(f_status), .busy(f_busy),
    .max_ss_n(f_ss_n), .max_sclk(f_sclk), .max_mosi(f_mosi), .max_miso(f_miso)
  );

  // Slave model: presents its first bit at select, shifts on each SCLK fall.
  logic [15:0] miso_word = 16'h0000;
  logic [15:0] miso_sr   = 16'h0000;
  assign miso = miso_sr[15];
  always @(negedge ss_n) miso_sr = miso_word;
  always @(negedge sclk) miso_sr = {miso_sr[14:0], 1'b0};

  // Pin monitors
  logic [15:0] mosi_cap   = 16'h0000;
  logic [15:0] f_mosi_cap = 16'h0000;
  int ss_low_cnt = 0;
  int done_seen  = 0;
  int cyc        = 0;
  int f_last_rise = 0;
  int f_period    = 0;

  always @(posedge sclk)   mosi_cap   = {mosi_cap[14:0], mosi};
  always @(posedge f_sclk) f_mosi_cap = {f_mosi_cap[14:0], f_mosi};
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!ss_n) ss_low_cnt = ss_low_cnt + 1;
    if (done != 2'b00) done_seen = done_seen + 1;
  end
  always @(posedge f_sclk) begin
    f_period    = cyc - f_last_rise;
    f_last_rise = cyc;
  end

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges from the call until a done pulse is visible (or the budget runs out).
  task automatic wait_done(input bit fast, input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (((fast ? f_done : done) == 2'b00) && (n < budget));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && (n < 500)) begin
      tick();
      n++;
    end
    check("idle_reached", {31'd0, busy}, 32'd0);
    @(negedge clk);
  endtask

  // After a done edge: the pulse must be one cycle wide and the select must stay high >= 4 cycles.
  task automatic check_gap(input string tag);
    int cnt;
    tick();
    check({tag, "_done_width"}, {30'd0, done}, 32'd0);
    cnt = 1;
    while (ss_n && (cnt < 50)) begin
      tick();
      cnt++;
    end
    check({tag, "_ss_gap_ge4"}, {31'd0, (cnt >= 4)}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int d0;
    rst_n  = 1'b0;
    req0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
    f_req0 = 1'b0; f_wr0 = 1'b0; f_addr0 = '0; f_wdata0 = '0;
    f_req1 = 1'b0; f_wr1 = 1'b0; f_addr1 = '0; f_wdata1 = '0;

    // Reset state, with both requests already raised
    repeat (3) tick();
    req0 = 1'b1; req1 = 1'b1;
    tick();
    check("rst_ss_n",   {31'd0, ss_n}, 32'd1);
    check("rst_sclk",   {31'd0, sclk}, 32'd0);
    check("rst_mosi",   {31'd0, mosi}, 32'd0);
    check("rst_done",   {30'd0, done}, 32'd0);
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_rdata",  {24'd0, rdata}, 32'd0);
    check("rst_status", {24'd0, status}, 32'd0);
    check("rst_f_ss_n", {31'd0, f_ss_n}, 32'd1);

    // Contention: grants 0, 1, 0
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(1'b0, 300, n);
    check("cont1_cycle", n, 32'd137);
    check("cont1_done", {30'd0, done}, 32'd1);
    check_gap("cont1");
    wait_done(1'b0, 300, n);
    check("cont2_done", {30'd0, done}, 32'd2);
    check_gap("cont2");
    wait_done(1'b0, 300, n);
    req0 = 1'b0; req1 = 1'b0;
    check("cont3_done", {30'd0, done}, 32'd1);
    tick();
    check("cont3_done_width", {30'd0, done}, 32'd0);
    wait_idle();

    // Write: req0, addr 5'h11, data 8'hA5
    miso_word = 16'hC35A;
    ss_low_cnt = 0;
    req0 = 1'b1; wr0 = 1'b1; addr0 = 5'h11; wdata0 = 8'hA5;
    wait_done(1'b0, 300, n);
    req0 = 1'b0; wr0 = 1'b0; addr0 = 5'h00; wdata0 = 8'h00;
    check("wr_cycle",  n, 32'd137);
    check("wr_done",   {30'd0, done}, 32'd1);
    check("wr_mosi",   {16'd0, mosi_cap}, 32'h8AA5);
    check("wr_ss_low", ss_low_cnt, 32'd136);
    check("wr_rdata",  {24'd0, rdata}, 32'h5A);
    check("wr_status", {24'd0, status}, 32'hC3);
    tick();
    check("wr_done_width", {30'd0, done}, 32'd0);
    check("wr_rdata_hold", {24'd0, rdata}, 32'h5A);
    tick(); tick();
    check("wr_busy_in_gap", {31'd0, busy}, 32'd1);
    tick();
    check("wr_busy_fall", {31'd0, busy}, 32'd0);
    @(negedge clk);

    // Read: req1, addr 5'h13, slave returns 8'h55 then 8'h3C
    miso_word = 16'h553C;
    req1 = 1'b1; wr1 = 1'b0; addr1 = 5'h13; wdata1 = 8'hEE;
    wait_done(1'b0, 300, n);
    req1 = 1'b0;
    check("rd_cycle",  n, 32'd137);
    check("rd_done",   {30'd0, done}, 32'd2);
    check("rd_mosi",   {16'd0, mosi_cap}, 32'h9800);
    check("rd_status", {24'd0, status}, 32'h55);
    check("rd_rdata",  {24'd0, rdata}, 32'h3C);
    wait_idle();

    // Request dropped and address changed mid-frame
    miso_word = 16'hA1B2;
    req0 = 1'b1; wr0 = 1'b0; addr0 = 5'h05; wdata0 = 8'h00;
    repeat (20) tick();
    req0 = 1'b0; addr0 = 5'h1F; wr0 = 1'b1;
    wait_done(1'b0, 300, n);
    check("drop_cycle",  n + 20, 32'd137);
    check("drop_done",   {30'd0, done}, 32'd1);
    check("drop_mosi",   {16'd0, mosi_cap}, 32'h2800);
    check("drop_rdata",  {24'd0, rdata}, 32'hB2);
    check("drop_status", {24'd0, status}, 32'hA1);
    wait_idle();

    // Reset at cycle 50 of a frame, then a clean frame
    miso_word = 16'h0F0F;
    d0 = done_seen;
    req0 = 1'b1; wr0 = 1'b1; addr0 = 5'h02; wdata0 = 8'h77;
    repeat (50) tick();
    check("rstmid_ss_low_before", {31'd0, ss_n}, 32'd0);
    rst_n = 1'b0;
    req0  = 1'b0;
    #1;
    check("rstmid_ss_n",   {31'd0, ss_n}, 32'd1);
    check("rstmid_sclk",   {31'd0, sclk}, 32'd0);
    check("rstmid_busy",   {31'd0, busy}, 32'd0);
    check("rstmid_rdata",  {24'd0, rdata}, 32'd0);
    check("rstmid_status", {24'd0, status}, 32'd0);
    repeat (3) tick();
    check("rstmid_no_done", done_seen, d0);
    @(negedge clk);
    req0  = 1'b1;
    rst_n = 1'b1;
    wait_done(1'b0, 300, n);
    req0 = 1'b0;
    check("rstmid_next_cycle", n, 32'd137);
    check("rstmid_next_done",  {30'd0, done}, 32'd1);
    check("rstmid_next_mosi",  {16'd0, mosi_cap}, 32'h1277);
    check("rstmid_next_rdata", {24'd0, rdata}, 32'h0F);
    wait_idle();

    // Minimum divider: write 8'hFF to register 0
    f_req0 = 1'b1; f_wr0 = 1'b1; f_addr0 = 5'h00; f_wdata0 = 8'hFF;
    wait_done(1'b1, 100, n);
    f_req0 = 1'b0;
    check("fast_cycle",  n, 32'd35);
    check("fast_done",   {30'd0, f_done}, 32'd1);
    check("fast_mosi",   {16'd0, f_mosi_cap}, 32'h02FF);
    check("fast_period", f_period, 32'd2);
    check("fast_rdata",  {24'd0, f_rdata}, 32'hFF);
    tick();
    check("fast_done_width", {30'd0, f_done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/max_spi_arbiter.md
MAX_SPI_ARBITER -- requirements
Module: max_spi_arbiter

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, giving clk cycles per SCLK half-period; legal range is 1 to 255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock (50 MHz board clock).
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req0, input, 1 bit: requester 0 transaction request, a level.
REQ-005 The block SHALL have port wr0, input, 1 bit: requester 0 direction, 1 = register write, 0 = register read.
REQ-006 The block SHALL have port addr0, input, 5 bits: requester 0 MAX3421E register number.
REQ-007 The block SHALL have port wdata0, input, 8 bits: requester 0 write data.
REQ-008 The block SHALL have ports req1, wr1, addr1 and wdata1, identical to REQ-004 to REQ-007, for requester 1.
REQ-009 The block SHALL have port done, output, 2 bits: a one-cycle completion pulse; bit n is for requester n.
REQ-010 The block SHALL have port rdata, output, 8 bits: data byte shifted in on MISO, valid when done is nonzero.
REQ-011 The block SHALL have port status, output, 8 bits: MISO byte captured during the command byte, valid when done is nonzero.
REQ-012 The block SHALL have port busy, output, 1 bit: high from grant until return to IDLE.
REQ-013 The block SHALL have ports max_ss_n (output), max_sclk (output), max_mosi (output) and max_miso (input), each 1 bit: the SPI pins.

Function
REQ-014 Each transaction SHALL be 16 SCLK bits, MSB first: a command byte, then a data byte.
- Command byte = {addr[4:0], 1'b0, wr, 1'b0}.
- Data byte = wdata for a write, 8'h00 for a read.
REQ-015 SPI mode 0 SHALL be used:
- max_sclk idles low.
- max_mosi changes only at the start of an SCLK low phase.
- max_miso is sampled on the clk edge where max_sclk goes high.
REQ-016 The FSM SHALL have the states IDLE, SETUP, SHIFT, HOLD and GAP, with these transitions:
- IDLE -> SETUP when any req is high; the grant, wr, addr and wdata are latched on that edge.
- SETUP (max_ss_n low, CLK_DIV cycles) -> SHIFT.
- SHIFT (16 bits × 2·CLK_DIV cycles) -> HOLD.
- HOLD (max_sclk low, CLK_DIV cycles) -> GAP.
- GAP (max_ss_n high, CLK_DIV cycles) -> IDLE.
REQ-017 The first bit SHALL be driven on max_mosi at SETUP entry; each subsequent bit SHALL be driven at the start of each later SCLK low phase.
REQ-018 done[g] SHALL pulse for exactly one cycle, in the first GAP cycle, where g is the granted requester.
- If req is sampled in IDLE at cycle 0, done occurs at cycle 1+34·CLK_DIV.
- busy falls at cycle 1+35·CLK_DIV.
REQ-019 rdata and status SHALL update at done and hold their value until the next done; for writes, rdata carries the shifted-in MISO byte.
REQ-020 Arbitration SHALL be round-robin and evaluated only in IDLE.
- With one req high, that requester wins.
- With both high, the requester not granted last wins.
- After reset, requester 0 has priority.
REQ-021 The handshake SHALL work as follows:
- Requester inputs are sampled only at grant, so later changes do not affect the transaction in flight.
- A req dropped mid-transaction does not abort it; done still pulses.
- A req still high in the cycle after done is a new request.
REQ-022 A new transaction SHALL never start while busy; requests arriving while busy SHALL wait and SHALL NOT be lost while held.
REQ-023 With CLK_DIV=1, timing SHALL scale exactly: SCLK = clk/2 and done at cycle 35.

Reset
REQ-024 While rst_n is low, asynchronously and regardless of state, the block SHALL force:
- max_ss_n=1, max_sclk=0, max_mosi=0
- done=0, busy=0, rdata=0, status=0
- FSM=IDLE, last-grant = requester 1 (so requester 0 wins first)
REQ-025 Reset mid-transaction SHALL abort with no done pulse; the first IDLE evaluation SHALL occur on the first clk edge after rst_n rises.

Verification
REQ-026 The bench SHALL cover a write. Stimulus: req0 high, wr0=1, addr0=5'h11, wdata0=8'hA5, CLK_DIV=4. Required response: MOSI carries 8'h8A then 8'hA5, max_ss_n is low for 34·4=136 cycles, and done=2'b01 at cycle 137.
REQ-027 The bench SHALL cover a read. Stimulus: req1 high, wr1=0, addr1=5'h13, with the MISO model returning 8'h55 then 8'h3C. Required response: MOSI carries 8'h98 then 8'h00, and done=2'b10 with status=8'h55 and rdata=8'h3C.
REQ-028 The bench SHALL cover contention. Stimulus: req0 and req1 held high from reset through 3 transactions. Required response: grants occur in order 0,1,0, each done is 1 cycle wide, and max_ss_n is high for ≥4 cycles between frames.
REQ-029 The bench SHALL cover reset mid-frame. Stimulus: rst_n pulled low at cycle 50 of a frame. Required response: max_ss_n=1 and max_sclk=0 in the same cycle, no done occurs, and a following request completes normally.
REQ-030 The bench SHALL cover a mid-frame request drop. Stimulus: req0 dropped and addr0 changed at cycle 20. Required response: the frame completes with the original command byte and done[0] pulses.
REQ-031 The bench SHALL cover the minimum divider. Stimulus: CLK_DIV=1, a write to 5'h00 with 8'hFF. Required response: SCLK period is 2 cycles, MOSI carries 8'h02 then 8'hFF, and done occurs at cycle 35.
